// File: rtl/blram_pkg.sv
// Shared types and helpers for the dual-port block RAM (blram_dp).
package blram_pkg;

   typedef enum logic [1:0] {
      StHold,
      StClear,
      StReady
   } blram_state_e;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 2;

   // Widest word byte_merge handles; callers zero-extend and truncate.
   localparam int unsigned MERGE_W = 256;

   function automatic logic [MERGE_W-1:0] byte_merge(
      input logic [MERGE_W-1:0]   old_w,
      input logic [MERGE_W-1:0]   new_w,
      input logic [MERGE_W/8-1:0] be
   );
      logic [MERGE_W-1:0] res;
      res = old_w;
      for (int i = 0; i < int'(MERGE_W / 8); i++) begin
         if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/blram_rd_pipe.sv
// Per-port read latency stage: valid/data shift register of depth RD_LAT.
module blram_rd_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o
);

   logic [RD_LAT-1:0] valid_q;
   logic [DATA_W-1:0] data_q [RD_LAT];

   // Data stages only load behind a valid, so the output holds between pulses.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int i = 0; i < int'(RD_LAT); i++) data_q[i] <= '0;
      end else begin
         valid_q[0] <= valid_i;
         if (valid_i) data_q[0] <= data_i;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) data_q[i] <= data_q[i-1];
         end
      end
   end

   assign valid_o = valid_q[RD_LAT-1];
   assign data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/blram_dp.sv
// Dual-port block RAM: port A read/write with byte enables, port B read-only,
// optional post-reset zero sweep. BLRAM_OOR_ERR_EN adds range checks and oor_err_o.
module blram_dp
   import blram_pkg::*;
#(
   parameter int unsigned ADDR_W       = 14,
   parameter int unsigned DEPTH        = 1024,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned RD_LAT       = 1,
   parameter bit          CLEAR_ON_RST = 1'b1,
   parameter string       INIT_FILE    = ""
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                a_en_i,
   input  logic                a_we_i,
   input  logic [DATA_W/8-1:0] a_be_i,
   input  logic [ADDR_W-1:0]   a_addr_i,
   input  logic [DATA_W-1:0]   a_wdata_i,
   output logic [DATA_W-1:0]   a_rdata_o,
   output logic                a_rvalid_o,
   input  logic                b_en_i,
   input  logic [ADDR_W-1:0]   b_addr_i,
   output logic [DATA_W-1:0]   b_rdata_o,
   output logic                b_rvalid_o,
   output logic                busy_o
`ifdef BLRAM_OOR_ERR_EN
   ,
   output logic                oor_err_o
`endif
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Out-of-range latencies clamp to the nearest legal value.
   localparam int unsigned LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                 (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem_q [DEPTH];

   blram_state_e     state_q;
   logic [IDX_W-1:0] clr_addr_q;
   logic             busy_q;

   logic             ready;
   logic             clr_we;
   logic [IDX_W-1:0] a_idx;
   logic [IDX_W-1:0] b_idx;
   logic             a_oor;
   logic             b_oor;
   logic             a_wr;
   logic             a_rd;
   logic             b_rd;
   logic [DATA_W-1:0] a_rd_data;
   logic [DATA_W-1:0] b_rd_data;
   logic [MERGE_W-1:0] a_merge_wide;
   logic [DATA_W-1:0] a_merged;
   logic              unused_bits;

   assign ready = (state_q == StReady);
   // HOLD keeps clr_addr_q at 0, so the first released cycle already clears word 0.
   assign clr_we = CLEAR_ON_RST && rst_ni && (state_q != StReady);

   assign a_idx = a_addr_i[IDX_W-1:0];
   assign b_idx = b_addr_i[IDX_W-1:0];

`ifdef BLRAM_OOR_ERR_EN
   logic oor_err_q;

   assign a_oor = (32'(a_addr_i) >= DEPTH);
   assign b_oor = (32'(b_addr_i) >= DEPTH);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         oor_err_q <= 1'b0;
      end else if ((a_en_i && ready && a_oor) || (b_en_i && ready && b_oor)) begin
         oor_err_q <= 1'b1;
      end
   end

   assign oor_err_o = oor_err_q;
`else
   assign a_oor = 1'b0;
   assign b_oor = 1'b0;
`endif

   assign a_wr = a_en_i && ready && a_we_i && !a_oor;
   assign a_rd = a_en_i && ready && !a_we_i;
   assign b_rd = b_en_i && ready;

   // Combinational array read feeding the pipe gives read-first collision behaviour.
   assign a_rd_data = a_oor ? '0 : mem_q[a_idx];
   assign b_rd_data = b_oor ? '0 : mem_q[b_idx];

   assign a_merge_wide = byte_merge(MERGE_W'(mem_q[a_idx]), MERGE_W'(a_wdata_i),
                                    (MERGE_W/8)'(a_be_i));
   assign a_merged     = a_merge_wide[DATA_W-1:0];
   assign unused_bits  = ^{a_addr_i, b_addr_i, a_merge_wide};

   always_ff @(posedge clk_i) begin
      if (clr_we) begin
         mem_q[clr_addr_q] <= '0;
      end else if (a_wr) begin
         mem_q[a_idx] <= a_merged;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StHold;
         clr_addr_q <= '0;
         busy_q     <= CLEAR_ON_RST;
      end else begin
         unique case (state_q)
            StHold: begin
               if (CLEAR_ON_RST && (DEPTH > 1)) begin
                  state_q    <= StClear;
                  clr_addr_q <= IDX_W'(1);
                  busy_q     <= 1'b1;
               end else begin
                  state_q <= StReady;
                  busy_q  <= 1'b0;
               end
            end
            StClear: begin
               if (clr_addr_q == LAST_IDX) begin
                  state_q    <= StReady;
                  clr_addr_q <= '0;
                  busy_q     <= 1'b0;
               end else begin
                  clr_addr_q <= clr_addr_q + IDX_W'(1);
               end
            end
            StReady: begin
               busy_q <= 1'b0;
            end
            default: begin
               state_q <= StHold;
               busy_q  <= CLEAR_ON_RST;
            end
         endcase
      end
   end

   assign busy_o = busy_q;

   blram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (LAT)
   ) u_a_pipe (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (a_rd),
      .data_i  (a_rd_data),
      .valid_o (a_rvalid_o),
      .data_o  (a_rdata_o)
   );

   blram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (LAT)
   ) u_b_pipe (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (b_rd),
      .data_i  (b_rd_data),
      .valid_o (b_rvalid_o),
      .data_o  (b_rdata_o)
   );

endmodule

// File: tb/tb_blram_dp.sv
// Directed bench for blram_dp: RD_LAT=2 and RD_LAT=1 copies share stimulus, plus a
// no-clear copy and (with BLRAM_OOR_ERR_EN) a DEPTH=1000 range-check copy.
module tb_blram_dp;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        a_en, a_we, b_en;
   logic [3:0]  a_be;
   logic [13:0] a_addr, b_addr;
   logic [31:0] a_wdata;

   logic [31:0] d2_a_rdata, d2_b_rdata, d1_a_rdata, d1_b_rdata, nc_a_rdata, nc_b_rdata;
   logic        d2_a_rvalid, d2_b_rvalid, d1_a_rvalid, d1_b_rvalid, nc_a_rvalid, nc_b_rvalid;
   logic        d2_busy, d1_busy, nc_busy;

   int n_chk = 0;
   int n_err = 0;
   int seen  = 0;
   int cnt;

   always #5 clk_i = ~clk_i;

`ifdef BLRAM_OOR_ERR_EN
   logic        d2_oor, d1_oor, nc_oor, oo_oor;
   logic [31:0] oo_a_rdata, oo_b_rdata;
   logic        oo_a_rvalid, oo_b_rvalid, oo_busy;

   blram_dp #(.ADDR_W(10), .DEPTH(1000), .DATA_W(32), .RD_LAT(1), .CLEAR_ON_RST(1'b1)) u_oor (
      .clk_i(clk_i), .rst_ni(rst_ni), .a_en_i(a_en), .a_we_i(a_we), .a_be_i(a_be),
      .a_addr_i(a_addr[9:0]), .a_wdata_i(a_wdata), .a_rdata_o(oo_a_rdata),
      .a_rvalid_o(oo_a_rvalid), .b_en_i(b_en), .b_addr_i(b_addr[9:0]),
      .b_rdata_o(oo_b_rdata), .b_rvalid_o(oo_b_rvalid), .busy_o(oo_busy), .oor_err_o(oo_oor));
`endif

   blram_dp #(.ADDR_W(14), .DEPTH(1024), .DATA_W(32), .RD_LAT(2), .CLEAR_ON_RST(1'b1)) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .a_en_i(a_en), .a_we_i(a_we), .a_be_i(a_be),
      .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_rdata_o(d2_a_rdata), .a_rvalid_o(d2_a_rvalid),
      .b_en_i(b_en), .b_addr_i(b_addr), .b_rdata_o(d2_b_rdata), .b_rvalid_o(d2_b_rvalid),
      .busy_o(d2_busy)
`ifdef BLRAM_OOR_ERR_EN
      , .oor_err_o(d2_oor)
`endif
   );

   blram_dp #(.ADDR_W(14), .DEPTH(1024), .DATA_W(32), .RD_LAT(1), .CLEAR_ON_RST(1'b1)) u_lat1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .a_en_i(a_en), .a_we_i(a_we), .a_be_i(a_be),
      .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_rdata_o(d1_a_rdata), .a_rvalid_o(d1_a_rvalid),
      .b_en_i(b_en), .b_addr_i(b_addr), .b_rdata_o(d1_b_rdata), .b_rvalid_o(d1_b_rvalid),
      .busy_o(d1_busy)
`ifdef BLRAM_OOR_ERR_EN
      , .oor_err_o(d1_oor)
`endif
   );

   blram_dp #(.ADDR_W(14), .DEPTH(16), .DATA_W(32), .RD_LAT(1), .CLEAR_ON_RST(1'b0)) u_nc (
      .clk_i(clk_i), .rst_ni(rst_ni), .a_en_i(a_en), .a_we_i(a_we), .a_be_i(a_be),
      .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_rdata_o(nc_a_rdata), .a_rvalid_o(nc_a_rvalid),
      .b_en_i(b_en), .b_addr_i(b_addr), .b_rdata_o(nc_b_rdata), .b_rvalid_o(nc_b_rvalid),
      .busy_o(nc_busy)
`ifdef BLRAM_OOR_ERR_EN
      , .oor_err_o(nc_oor)
`endif
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic wr_a(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] be);
      a_en = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data; a_be = be;
      tick();
      a_en = 1'b0; a_we = 1'b0;
   endtask

   task automatic rd_a(input logic [13:0] addr, input logic [31:0] exp, input string tag);
      a_en = 1'b1; a_we = 1'b0; a_addr = addr;
      tick();
      a_en = 1'b0;
      chk({tag, "_l1_v"}, 32'(d1_a_rvalid), 32'd1);
      chk({tag, "_l1_d"}, d1_a_rdata, exp);
      chk({tag, "_l2_early_v"}, 32'(d2_a_rvalid), 32'd0);
      tick();
      chk({tag, "_l2_v"}, 32'(d2_a_rvalid), 32'd1);
      chk({tag, "_l2_d"}, d2_a_rdata, exp);
      chk({tag, "_l1_drop_v"}, 32'(d1_a_rvalid), 32'd0);
   endtask

   task automatic rd_b(input logic [13:0] addr, input logic [31:0] exp, input string tag);
      b_en = 1'b1; b_addr = addr;
      tick();
      b_en = 1'b0;
      chk({tag, "_l1_v"}, 32'(d1_b_rvalid), 32'd1);
      chk({tag, "_l1_d"}, d1_b_rdata, exp);
      tick();
      chk({tag, "_l2_v"}, 32'(d2_b_rvalid), 32'd1);
      chk({tag, "_l2_d"}, d2_b_rdata, exp);
   endtask

   // Ticks until the RD_LAT=2 copy drops busy, counting cycles and stray rvalids.
   task automatic wait_ready(output int n);
      n = 0;
      do begin
         tick();
         n++;
         if (d2_a_rvalid || d2_b_rvalid || d1_a_rvalid || d1_b_rvalid) seen++;
      end while (d2_busy && n < 3000);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [31:0] lat_vals [3];

   initial begin
      lat_vals[0] = 32'h80190190;
      lat_vals[1] = 32'hA019412F;
      lat_vals[2] = 32'h60190065;
      rst_ni = 1'b0; a_en = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = '0; a_wdata = '0;
      b_en = 1'b0; b_addr = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_busy", 32'(d2_busy), 32'd1);
      chk("rst_nc_busy", 32'(nc_busy), 32'd0);
      chk("rst_a_rvalid", 32'(d2_a_rvalid), 32'd0);
      chk("rst_b_rvalid", 32'(d2_b_rvalid), 32'd0);
      chk("rst_a_rdata", d2_a_rdata, 32'd0);
      chk("rst_b_rdata", d1_b_rdata, 32'd0);

      // First clear sweep
      rst_ni = 1'b1;
      wait_ready(cnt);
      chk("clear1_cycles", 32'(cnt), 32'd1024);
      chk("clear1_lat1_busy", 32'(d1_busy), 32'd0);
      chk("nc_ready_busy", 32'(nc_busy), 32'd0);

      // Preload, then a full clear must wipe it
      wr_a(14'd0, 32'hDEADBEEF, 4'hF);
      wr_a(14'd511, 32'hDEADBEEF, 4'hF);
      wr_a(14'd1023, 32'hDEADBEEF, 4'hF);
      rd_a(14'd511, 32'hDEADBEEF, "preload511");

      // Reset mid-clear while hammering both ports with requests
      rst_ni = 1'b0; tick(); tick();
      rst_ni = 1'b1;
      a_en = 1'b1; a_we = 1'b1; a_addr = 14'd7; a_wdata = 32'hDEADBEEF; a_be = 4'hF;
      b_en = 1'b1; b_addr = 14'd511;
      seen = 0;
      repeat (300) tick();
      rst_ni = 1'b0; tick(); tick();
      chk("midclr_hold_busy", 32'(d2_busy), 32'd1);
      rst_ni = 1'b1;
      wait_ready(cnt);
      a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
      chk("clear2_cycles", 32'(cnt), 32'd1024);
      chk("busy_rvalids", 32'(seen), 32'd0);
      rd_a(14'd0, 32'h0, "clr0");
      rd_a(14'd511, 32'h0, "clr511");
      rd_a(14'd1023, 32'h0, "clr1023");
      rd_a(14'd7, 32'h0, "busywr7");

      // Byte enables
      wr_a(14'd5, 32'h11223344, 4'hF);
      wr_a(14'd5, 32'hAABBCCDD, 4'h5);
      rd_a(14'd5, 32'h11BB33DD, "be0101");
      wr_a(14'd5, 32'hFFFFFFFF, 4'h0);
      rd_a(14'd5, 32'h11BB33DD, "be0000");

      // Back-to-back reads
      for (int i = 0; i < 3; i++) wr_a(14'(i + 1), lat_vals[i], 4'hF);
      for (int t = 0; t < 5; t++) begin
         a_en = (t < 3); a_we = 1'b0; a_addr = 14'(t + 1);
         tick();
         chk($sformatf("b2b_l2_v%0d", t), 32'(d2_a_rvalid), 32'((t >= 1) && (t <= 3)));
         if (t >= 1 && t <= 3) chk($sformatf("b2b_l2_d%0d", t), d2_a_rdata, lat_vals[t-1]);
         chk($sformatf("b2b_l1_v%0d", t), 32'(d1_a_rvalid), 32'(t <= 2));
         if (t <= 2) chk($sformatf("b2b_l1_d%0d", t), d1_a_rdata, lat_vals[t]);
      end
      a_en = 1'b0;
      chk("b2b_hold_l2", d2_a_rdata, 32'h60190065);

      // Collision: A write vs B read, same address
      wr_a(14'd302, 32'hB, 4'hF);
      a_en = 1'b1; a_we = 1'b1; a_addr = 14'd302; a_wdata = 32'h1F5; a_be = 4'hF;
      b_en = 1'b1; b_addr = 14'd302;
      tick();
      a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
      chk("coll_l1_v", 32'(d1_b_rvalid), 32'd1);
      chk("coll_l1_d", d1_b_rdata, 32'hB);
      tick();
      chk("coll_l2_d", d2_b_rdata, 32'hB);
      rd_b(14'd302, 32'h1F5, "coll_next");

      // No-clear copy keeps contents through reset and wraps addresses
      wr_a(14'd9, 32'h12345678, 4'hF);
      rst_ni = 1'b0; repeat (3) tick();
      chk("nc_rst_busy", 32'(nc_busy), 32'd0);
      rst_ni = 1'b1;
      tick();
      a_en = 1'b1; a_we = 1'b0; a_addr = 14'd9;
      tick();
      chk("nc_keep_v", 32'(nc_a_rvalid), 32'd1);
      chk("nc_keep_d", nc_a_rdata, 32'h12345678);
      chk("busy_no_rvalid", 32'(d1_a_rvalid), 32'd0);
      a_addr = 14'd25;
      tick();
      a_en = 1'b0;
      chk("nc_wrap_d", nc_a_rdata, 32'h12345678);
      wait_ready(cnt);
      chk("clear3_done", 32'(d2_busy), 32'd0);
      rd_a(14'd9, 32'h0, "clr9");

`ifdef BLRAM_OOR_ERR_EN
      wr_a(14'd488, 32'h00488488, 4'hF);
      chk("oor_clean", 32'(oo_oor), 32'd0);
      wr_a(14'd1000, 32'hDEADBEEF, 4'hF);
      chk("oor_set_wr", 32'(oo_oor), 32'd1);
      a_en = 1'b1; a_we = 1'b0; a_addr = 14'd1000;
      tick();
      a_en = 1'b0;
      chk("oor_rd_v", 32'(oo_a_rvalid), 32'd1);
      chk("oor_rd_d", oo_a_rdata, 32'h0);
      a_en = 1'b1; a_addr = 14'd488;
      tick();
      a_en = 1'b0;
      chk("oor_488_d", oo_a_rdata, 32'h00488488);
      tick();
      chk("oor_sticky", 32'(oo_oor), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
